// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH:0]       rem_q;
  logic [WIDTH-1:0]     b_mag_q, a_raw_q;
  logic                 is_div_q, b_zero_q, neg_lo_q, neg_hi_q;

  logic                 a_neg, b_neg, zero_cond, accept, last_iter, write_res;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH+1:0]     div_trial, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rmd, res_hi, res_lo;

  always_comb begin
    a_neg     = op[0] & src_a[WIDTH-1];
    b_neg     = op[0] & src_b[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
    zero_cond = op[1] ? (src_b == '0) : ((src_a == '0) || (src_b == '0));
    accept    = (state_q == IDLE) && start && !flush;
    last_iter = (cnt_q == CW'(WIDTH - 1));
    write_res = (state_q == FIX) && !flush;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (ZERO_SKIP && zero_cond) ? FIX : ITER;
      ITER:    if (flush) state_d = IDLE;
               else if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath step: multiplier/dividend sits in acc_q[W-1:0] and shifts out one bit per cycle
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_mag_q};
    div_trial = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_trial - {2'b00, b_mag_q};
    div_ge    = !div_diff[WIDTH+1];
  end

  always_comb begin
    prod = (b_zero_q || (a_raw_q == '0)) ? '0 : acc_q;
    if (neg_lo_q) prod = -prod;
    quo    = acc_q[WIDTH-1:0];
    rmd    = rem_q[WIDTH-1:0];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (b_zero_q) begin
        res_lo = '1;
        res_hi = a_raw_q;
      end else begin
        res_lo = neg_lo_q ? -quo : quo;
        res_hi = neg_hi_q ? -rmd : rmd;
      end
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      b_mag_q  <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      acc_q    <= {{WIDTH{1'b0}}, a_mag};
      rem_q    <= '0;
      b_mag_q  <= b_mag;
      a_raw_q  <= src_a;
      is_div_q <= op[1];
      b_zero_q <= (src_b == '0);
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg;
    end else if (state_q == ITER) begin
      cnt_q <= (last_iter || flush) ? '0 : cnt_q + CW'(1);
      if (is_div_q) begin
        rem_q              <= div_ge ? div_diff[WIDTH:0] : div_trial[WIDTH:0];
        acc_q[WIDTH-1:0]   <= {acc_q[WIDTH-2:0], div_ge};
      end else if (acc_q[0]) begin
        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
      end else begin
        acc_q <= {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  // A result written on the completion edge takes priority over MTHI/MTLO
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= write_res;
      if (write_res) begin
        hi <= res_hi;
        lo <= res_lo;
        if (is_div_q) div_zero <= b_zero_q;
      end else begin
        if (hi_we) hi <= wr_data;
        if (lo_we) lo <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wr_data;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

  muldiv_unit #(.WIDTH(32), .ZERO_SKIP(1'b1)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Launch an op and wait for done; lat counts negedges after the accept edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcyc);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcyc = 0;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                     input int e_lat);
    int lat, bcyc;
    do_op(o, a, b, lat, bcyc);
    check({tag, "_lat"}, 64'(lat), 64'(e_lat));
    check({tag, "_hi"}, 64'(hi), 64'(e_hi));
    check({tag, "_lo"}, 64'(lo), 64'(e_lo));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, bcyc, cnt_d, cnt_b;
    reset_b = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset_b = 1'b1;

    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcyc);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_busy_cyc", 64'(bcyc), 64'd33);
    check("multu_hi", 64'(hi), 64'hFFFFFFFE);
    check("multu_lo", 64'(lo), 64'h00000001);
    @(negedge clk);
    check("multu_done_pulse", 64'(done), 64'd0);

    run("mult_m3x5",  2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 33);
    run("mult_7xm1",  2'b01, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 33);
    run("mult_zero",  2'b01, 32'd0,        32'hFFFFFFF9, 32'd0,        32'd0,        1);
    run("div_m7_2",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run("div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33);
    run("divu_100_7", 2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       33);
    check("dz_clear0", 64'(div_zero), 64'd0);
    run("divu_by0",   2'b10, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1);
    check("dz_set", 64'(div_zero), 64'd1);
    run("divu_9_3",   2'b10, 32'd9,        32'd3,        32'd0,        32'd3,        33);
    check("dz_clear", 64'(div_zero), 64'd0);

    // Flush mid-ITER with a competing start; preloaded HI must survive
    @(negedge clk); hi_we = 1'b1; wr_data = 32'hAAAA;
    @(negedge clk); hi_we = 1'b0;
    check("mthi", 64'(hi), 64'hAAAA);
    @(negedge clk); start = 1'b1; op = 2'b01; src_a = 32'hFFFFFFFD; src_b = 32'd5;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1; start = 1'b1; op = 2'b10; src_a = 32'd50; src_b = 32'd5;
    @(negedge clk); flush = 1'b0; start = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    cnt_d = 0; cnt_b = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt_d++;
      if (busy) cnt_b++;
    end
    check("flush_no_done", 64'(cnt_d), 64'd0);
    check("flush_start_ignored", 64'(cnt_b), 64'd0);
    check("flush_hi_kept", 64'(hi), 64'hAAAA);

    // start while busy ignored; MTLO mid-ITER visible, then overwritten
    @(negedge clk); start = 1'b1; op = 2'b00; src_a = 32'd6; src_b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'd99; src_b = 32'd9; lo_we = 1'b1; wr_data = 32'h5555;
    @(negedge clk); start = 1'b0; lo_we = 1'b0;
    check("mtlo_iter", 64'(lo), 64'h5555);
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    check("busy_start_lat", 64'(lat + 4), 64'd33);
    check("busy_start_lo", 64'(lo), 64'd42);
    check("busy_start_hi", 64'(hi), 64'd0);
    @(negedge clk);
    check("busy_start_noqueue", 64'(busy), 64'd0);

    // Signed divide by zero, then async reset during ITER
    run("div_m5_by0", 2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1);
    check("dz_signed", 64'(div_zero), 64'd1);
    @(negedge clk); start = 1'b1; op = 2'b00; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset_b = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_dz", 64'(div_zero), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk); reset_b = 1'b1;
    run("post_rst_divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
